// File: rtl/cmi_decoder.sv
`default_nettype none
// ============================================================================
// Module   : cmi_decoder
// Purpose  : CMI telemetry frame receiver. It hunts for SYNC, collects 8 bytes,
//            verifies the XOR checksum and publishes four 16-bit channels.
// Option   : CMI_DEC_ERRCNT_EN adds a saturating err_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module cmi_decoder #(
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         TIMEOUT_CLKS = 13020,
   parameter int         TO_W         = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_ena,
   input  logic [7:0]  rx_data,
   output logic [15:0] cmi_data0,
   output logic [15:0] cmi_data1,
   output logic [15:0] cmi_data2,
   output logic [15:0] cmi_data3,
   output logic        cmi_strob,
   output logic        chk_err,
   output logic        to_err,
`ifdef CMI_DEC_ERRCNT_EN
   output logic [15:0] err_cnt,
`endif
   output logic        busy
);

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      DATA = 2'd1,
      CHK  = 2'd2
   } state_t;

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CLKS);

   state_t               state;
   logic [TO_W-1:0]      timer;
   logic [2:0]           idx;
   logic [7:0]           acc;
   logic [7:0][7:0]      shadow;
   logic                 expired;

   // A byte arriving in the expiry cycle takes priority over the timeout.
   assign expired = (state != HUNT) && (timer == TO_LIMIT) && !rx_ena;
   assign busy    = (state != HUNT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= HUNT;
         timer     <= '0;
         idx       <= '0;
         acc       <= '0;
         shadow    <= '0;
         cmi_data0 <= '0;
         cmi_data1 <= '0;
         cmi_data2 <= '0;
         cmi_data3 <= '0;
         cmi_strob <= 1'b0;
         chk_err   <= 1'b0;
         to_err    <= 1'b0;
      end else begin
         cmi_strob <= 1'b0;
         chk_err   <= 1'b0;
         to_err    <= 1'b0;

         if (rx_ena || state == HUNT)
            timer <= '0;
         else
            timer <= timer + TO_W'(1);

         if (rx_ena) begin
            case (state)
               HUNT: begin
                  if (rx_data == SYNC_BYTE) begin
                     state <= DATA;
                     idx   <= '0;
                     acc   <= '0;
                  end
               end
               DATA: begin
                  shadow[idx] <= rx_data;
                  acc         <= acc ^ rx_data;
                  idx         <= idx + 3'd1;
                  if (idx == 3'd7)
                     state <= CHK;
               end
               CHK: begin
                  if (rx_data == acc) begin
                     cmi_data0 <= {shadow[0], shadow[1]};
                     cmi_data1 <= {shadow[2], shadow[3]};
                     cmi_data2 <= {shadow[4], shadow[5]};
                     cmi_data3 <= {shadow[6], shadow[7]};
                     cmi_strob <= 1'b1;
                  end else begin
                     chk_err <= 1'b1;
                  end
                  state <= HUNT;
               end
               default: state <= HUNT;
            endcase
         end else if (expired) begin
            to_err <= 1'b1;
            state  <= HUNT;
            timer  <= '0;
         end
      end
   end

`ifdef CMI_DEC_ERRCNT_EN
   logic err_evt;

   // Same qualifying conditions as the chk_err / to_err pulses, so the count
   // moves on the edge that raises the pulse.
   assign err_evt = (rx_ena && state == CHK && rx_data != acc) || expired;

   always_ff @(posedge clk) begin
      if (!rst)
         err_cnt <= '0;
      else if (err_evt && err_cnt != 16'hFFFF)
         err_cnt <= err_cnt + 16'd1;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmi_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmi_decoder
// Purpose  : Scoreboard bench for cmi_decoder (directed frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmi_decoder;

   localparam int TO = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx_ena = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic [15:0] cmi_data0, cmi_data1, cmi_data2, cmi_data3;
   logic        cmi_strob, chk_err, to_err, busy;
`ifdef CMI_DEC_ERRCNT_EN
   logic [15:0] err_cnt;
`endif

   cmi_decoder #(
      .SYNC_BYTE    (8'hA5),
      .TIMEOUT_CLKS (TO),
      .TO_W         (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_ena    (rx_ena),
      .rx_data   (rx_data),
      .cmi_data0 (cmi_data0),
      .cmi_data1 (cmi_data1),
      .cmi_data2 (cmi_data2),
      .cmi_data3 (cmi_data3),
      .cmi_strob (cmi_strob),
      .chk_err   (chk_err),
      .to_err    (to_err),
`ifdef CMI_DEC_ERRCNT_EN
      .err_cnt   (err_cnt),
`endif
      .busy      (busy)
   );

   always #10 clk = ~clk;

   // kind encoding mirrors {cmi_strob, chk_err, to_err}
   localparam int K_STROB = 4;
   localparam int K_CHK   = 2;
   localparam int K_TO    = 1;

   typedef struct {
      int          kind;
      int          at;
      logic [63:0] data;
   } exp_t;

   exp_t        q[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   bit          skip_hold = 1'b1;
   logic [63:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT raises any pulse.
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] cur;
      logic [2:0]  kind;
      cur  = {cmi_data0, cmi_data1, cmi_data2, cmi_data3};
      kind = {cmi_strob, chk_err, to_err};
      if (kind != 3'b000) begin
         check("pulse_exclusive", 64'(kind == 3'b100 || kind == 3'b010 || kind == 3'b001), 64'd1);
         if (q.size() == 0) begin
            check("unexpected_event", 64'(kind), 64'd0);
         end else begin
            e = q.pop_front();
            check("event_kind",  64'(kind), 64'(e.kind));
            check("event_cycle", 64'(cyc),  64'(e.at));
            if (kind == 3'b100)
               check("frame_data", cur, e.data);
         end
      end
      if (!skip_hold && !cmi_strob)
         check("hold_data", cur, prev_data);
      prev_data = cur;
   end

   // All stimulus tasks start and end on a falling edge.
   task automatic send(input logic [7:0] b);
      rx_ena  = 1'b1;
      rx_data = b;
      @(negedge clk);
      rx_ena  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_evt(input int kind, input int at, input logic [63:0] data);
      exp_t e;
      e.kind = kind;
      e.at   = at;
      e.data = data;
      q.push_back(e);
   endtask

   // f = {SYNC, d0..d7, CHK}; the event appears one clock after the CHK byte.
   task automatic send_frame(input logic [79:0] f, input int kind);
      for (int i = 9; i >= 1; i--) send(f[i*8 +: 8]);
      expect_evt(kind, cyc + 1, f[71:8]);
      send(f[7:0]);
   endtask

   task automatic do_reset();
      skip_hold = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      skip_hold = 1'b0;
   endtask

   // XOR of 12 34 56 78 9A BC DE F0 is 00, so 00 is the good checksum.
   localparam logic [79:0] F_GOOD = 80'hA5_12_34_56_78_9A_BC_DE_F0_00;
   localparam logic [79:0] F_BAD  = 80'hA5_12_34_56_78_9A_BC_DE_F0_09;
   localparam logic [79:0] F_ALL5 = 80'hA5_A5_A5_A5_A5_A5_A5_A5_A5_00;
   localparam logic [79:0] F_SEQ  = 80'hA5_11_22_33_44_55_66_77_88_88;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      idle(3);
      rst = 1'b1;
      idle(1);
      skip_hold = 1'b0;

      check("reset_data",  {cmi_data0, cmi_data1, cmi_data2, cmi_data3}, 64'd0);
      check("reset_pulse", 64'({cmi_strob, chk_err, to_err}), 64'd0);
      check("reset_busy",  64'(busy), 64'd0);

      // Bad checksum on a fresh device: data stays zero.
      send_frame(F_BAD, K_CHK);
      idle(1);
      check("bad_chk_data", {cmi_data0, cmi_data1, cmi_data2, cmi_data3}, 64'd0);
      check("bad_chk_busy", 64'(busy), 64'd0);

      // Good frame, then noise + all-A5 frame, then a back-to-back frame.
      send_frame(F_GOOD, K_STROB);
      send(8'h00);
      send(8'hFF);
      send_frame(F_ALL5, K_STROB);
      send_frame(F_SEQ, K_STROB);
      idle(2);

      // Byte arriving exactly on the expiry cycle is accepted.
      send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
      idle(TO);
      check("stall_busy", 64'(busy), 64'd1);
      send(8'h04); send(8'h05); send(8'h06); send(8'h07); send(8'h08);
      expect_evt(K_STROB, cyc + 1, 64'h0102_0304_0506_0708);
      send(8'h08);
      idle(2);

      // Inter-byte timeout, then recovery.
      send(8'hA5); send(8'hDE); send(8'hAD); send(8'hBE);
      expect_evt(K_TO, cyc + TO + 1, 64'd0);
      idle(TO + 5);
      check("timeout_busy", 64'(busy), 64'd0);
      send_frame(F_GOOD, K_STROB);
      idle(2);

      // Reset after byte 5 of a frame.
      send(8'hA5); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h9A);
      do_reset();
      check("midreset_data", {cmi_data0, cmi_data1, cmi_data2, cmi_data3}, 64'd0);
      check("midreset_busy", 64'(busy), 64'd0);
      send(8'hBC); send(8'hDE); send(8'hF0); send(8'h00);
      check("midreset_ignored_busy", 64'(busy), 64'd0);
      idle(2);
      send_frame(F_SEQ, K_STROB);
      idle(2);

`ifdef CMI_DEC_ERRCNT_EN
      do_reset();
      check("errcnt_reset", 64'(err_cnt), 64'd0);
      for (int i = 0; i < 3; i++) send_frame(F_BAD, K_CHK);
      send(8'hA5); send(8'h01);
      expect_evt(K_TO, cyc + TO + 1, 64'd0);
      idle(TO + 3);
      check("errcnt_four", 64'(err_cnt), 64'd4);
      force dut.err_cnt = 16'hFFFF;
      idle(1);
      release dut.err_cnt;
      send_frame(F_BAD, K_CHK);
      idle(2);
      check("errcnt_saturate", 64'(err_cnt), 64'hFFFF);
`endif

      idle(5);
      check("scoreboard_empty", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
